// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB pipeline register for the 16-bit pipeline.
// Runs one data-memory load or store at a time over a req/ready handshake,
// stalls upstream while the access is outstanding, and registers the
// writeback triple (regwrite, dest reg, data) for the register file.
module mem_wb_stage #(
    parameter int          TIMEOUT  = 16,       // ACCESS cycles before abort, 2..255
    parameter logic [15:0] ERR_DATA = 16'hFFFF  // writeback data on a timed-out access
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_regwrite_in,
    input  logic [3:0]  destreg_in,
    input  logic        set_memwrite_in,
    input  logic        set_memread_in,
    input  logic [15:0] addr_in,
    input  logic [15:0] store_data_in,
    input  logic [15:0] result_in,
    input  logic [7:0]  opcode_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ready,
    output logic        stall_out,
    output logic        set_regwrite_out,
    output logic [3:0]  destreg_out,
    output logic [15:0] wb_data_out,
    output logic [7:0]  opcode_out,
    output logic        err_timeout_out
);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t     state_q, state_d;
    logic [7:0] count_q;
    logic       access_in;
    logic       timeout_hit;
    logic       do_pass;      // IDLE, no memory op: plain writeback
    logic       do_issue;     // IDLE, memory op: start the request
    logic       do_wait;      // ACCESS, memory not ready yet
    logic       do_complete;  // ACCESS, memory finished this cycle
    logic       do_abort;     // ACCESS, last allowed cycle without ready

    // Next-state decode plus the one-hot action strobes for the register block.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d     = state_q;
        stall_out   = 1'b0;
        do_pass     = 1'b0;
        do_issue    = 1'b0;
        do_wait     = 1'b0;
        do_complete = 1'b0;
        do_abort    = 1'b0;
        access_in   = set_memread_in | set_memwrite_in;
        timeout_hit = (count_q == 8'(TIMEOUT - 1));

        // While reset is asserted nothing is decoded, so stall_out stays 0.
        if (reset) begin
            case (state_q)
                IDLE: begin
                    if (access_in) begin
                        do_issue  = 1'b1;
                        stall_out = 1'b1;
                        state_d   = ACCESS;
                    end else begin
                        do_pass = 1'b1;
                    end
                end
                ACCESS: begin
                    // A ready on the last allowed cycle still completes normally.
                    if (dmem_ready) begin
                        do_complete = 1'b1;
                        state_d     = IDLE;
                    end else if (timeout_hit) begin
                        do_abort = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        do_wait   = 1'b1;
                        stall_out = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, request interface, timeout counter and MEM/WB register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            state_q          <= IDLE;
            count_q          <= 8'd0;
            dmem_req         <= 1'b0;
            dmem_we          <= 1'b0;
            dmem_addr        <= 16'd0;
            dmem_wdata       <= 16'd0;
            set_regwrite_out <= 1'b0;
            destreg_out      <= 4'd0;
            wb_data_out      <= 16'd0;
            opcode_out       <= 8'd0;
            err_timeout_out  <= 1'b0;
        end else begin
            state_q <= state_d;

            if (do_pass) begin
                set_regwrite_out <= set_regwrite_in;
                destreg_out      <= destreg_in;
                wb_data_out      <= result_in;
                opcode_out       <= opcode_in;
            end

            // Store wins when both read and write are flagged.
            if (do_issue) begin
                dmem_req         <= 1'b1;
                dmem_we          <= set_memwrite_in;
                dmem_addr        <= addr_in;
                dmem_wdata       <= store_data_in;
                count_q          <= 8'd0;
                set_regwrite_out <= 1'b0;
            end

            if (do_wait) begin
                count_q          <= count_q + 8'd1;
                set_regwrite_out <= 1'b0;
            end

            if (do_complete) begin
                dmem_req         <= 1'b0;
                set_regwrite_out <= set_regwrite_in;
                destreg_out      <= destreg_in;
                opcode_out       <= opcode_in;
                wb_data_out      <= dmem_we ? result_in : dmem_rdata;
            end

            // The flag stays set until the next reset.
            if (do_abort) begin
                dmem_req         <= 1'b0;
                set_regwrite_out <= 1'b0;
                destreg_out      <= destreg_in;
                opcode_out       <= opcode_in;
                wb_data_out      <= ERR_DATA;
                err_timeout_out  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed testbench for mem_wb_stage: ALU pass-through, load with wait
// states, single-cycle store, timeout abort, reset mid-access and
// back-to-back loads.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        set_regwrite_in;
    logic [3:0]  destreg_in;
    logic        set_memwrite_in;
    logic        set_memread_in;
    logic [15:0] addr_in;
    logic [15:0] store_data_in;
    logic [15:0] result_in;
    logic [7:0]  opcode_in;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_ready;
    logic        stall_out;
    logic        set_regwrite_out;
    logic [3:0]  destreg_out;
    logic [15:0] wb_data_out;
    logic [7:0]  opcode_out;
    logic        err_timeout_out;

    int total = 0;
    int bad   = 0;

    mem_wb_stage dut (
        .clk              (clk),
        .reset            (reset),
        .set_regwrite_in  (set_regwrite_in),
        .destreg_in       (destreg_in),
        .set_memwrite_in  (set_memwrite_in),
        .set_memread_in   (set_memread_in),
        .addr_in          (addr_in),
        .store_data_in    (store_data_in),
        .result_in        (result_in),
        .opcode_in        (opcode_in),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_rdata       (dmem_rdata),
        .dmem_ready       (dmem_ready),
        .stall_out        (stall_out),
        .set_regwrite_out (set_regwrite_out),
        .destreg_out      (destreg_out),
        .wb_data_out      (wb_data_out),
        .opcode_out       (opcode_out),
        .err_timeout_out  (err_timeout_out)
    );

    always #5 clk = ~clk;

    // Inputs are driven 1 time unit after the rising edge, outputs are
    // checked 1 unit later, both well away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        set_regwrite_in = 1'b0;
        destreg_in      = 4'h0;
        set_memwrite_in = 1'b0;
        set_memread_in  = 1'b0;
        addr_in         = 16'h0000;
        store_data_in   = 16'h0000;
        result_in       = 16'h0000;
        opcode_in       = 8'h00;
    endtask

    task automatic test_reset();
        clear_inputs();
        dmem_ready = 1'b0;
        dmem_rdata = 16'h0000;
        reset      = 1'b0;
        step();
        step();
        set_memread_in = 1'b1;   // a memory op under reset must not stall
        #1;
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall_out); end
        total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", dmem_req); end
        total++; if ({set_regwrite_out, destreg_out, wb_data_out, opcode_out} !== 29'd0) begin bad++;
            $display("FAIL reset_wb got=%b/%h/%h/%h want=all zero", set_regwrite_out, destreg_out, wb_data_out, opcode_out); end
        total++; if (err_timeout_out !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_timeout_out); end
        clear_inputs();
        step();
        reset = 1'b1;
    endtask

    task automatic test_alu();
        set_regwrite_in = 1'b1;
        destreg_in      = 4'h3;
        result_in       = 16'h1234;
        opcode_in       = 8'h21;
        #1;
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL alu_stall got=%b want=0", stall_out); end
        step();
        clear_inputs();
        #1;
        total++; if (set_regwrite_out !== 1'b1) begin bad++; $display("FAIL alu_regwrite got=%b want=1", set_regwrite_out); end
        total++; if (destreg_out !== 4'h3) begin bad++; $display("FAIL alu_dest got=%h want=3", destreg_out); end
        total++; if (wb_data_out !== 16'h1234) begin bad++; $display("FAIL alu_data got=%h want=1234", wb_data_out); end
        total++; if (opcode_out !== 8'h21) begin bad++; $display("FAIL alu_opcode got=%h want=21", opcode_out); end
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL alu_stall2 got=%b want=0", stall_out); end
    endtask

    // Presents a load now, waits `waits` not-ready cycles, then returns the
    // data. Returns one unit after the completion edge without clearing the
    // ex_mem inputs so the caller can chain another instruction.
    task automatic do_load(input logic [15:0] addr, input logic [15:0] rdata,
                           input int waits, input logic [3:0] dest);
        set_regwrite_in = 1'b1;
        destreg_in      = dest;
        set_memread_in  = 1'b1;
        set_memwrite_in = 1'b0;
        addr_in         = addr;
        result_in       = 16'h5555;
        opcode_in       = 8'h40;
        #1;
        total++; if (stall_out !== 1'b1) begin bad++; $display("FAIL ld_issue_stall got=%b want=1", stall_out); end
        for (int i = 0; i <= waits; i++) begin
            step();
            dmem_ready = (i == waits);
            dmem_rdata = (i == waits) ? rdata : 16'hDEAD;
            #1;
            total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== addr) begin bad++;
                $display("FAIL ld_req cyc=%0d got=%b/%b/%h want=1/0/%h", i, dmem_req, dmem_we, dmem_addr, addr); end
            total++; if (stall_out !== (i != waits)) begin bad++;
                $display("FAIL ld_stall cyc=%0d got=%b want=%b", i, stall_out, (i != waits)); end
            total++; if (set_regwrite_out !== 1'b0) begin bad++;
                $display("FAIL ld_bubble cyc=%0d got=%b want=0", i, set_regwrite_out); end
        end
        step();
        dmem_ready = 1'b0;
        dmem_rdata = 16'h0000;
        #1;
        total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL ld_req_drop got=%b want=0", dmem_req); end
        total++; if (set_regwrite_out !== 1'b1 || destreg_out !== dest) begin bad++;
            $display("FAIL ld_wb_ctl got=%b/%h want=1/%h", set_regwrite_out, destreg_out, dest); end
        total++; if (wb_data_out !== rdata) begin bad++; $display("FAIL ld_wb_data got=%h want=%h", wb_data_out, rdata); end
    endtask

    task automatic test_load();
        do_load(16'h00F0, 16'hBEEF, 2, 4'h7);
        clear_inputs();
        step();
        #1;
        total++; if (set_regwrite_out !== 1'b0) begin bad++; $display("FAIL ld_single_write got=%b want=0", set_regwrite_out); end
    endtask

    task automatic test_store();
        set_regwrite_in = 1'b0;
        set_memwrite_in = 1'b1;
        set_memread_in  = 1'b1;   // both flagged: treated as a store
        addr_in         = 16'h0010;
        store_data_in   = 16'hA5A5;
        result_in       = 16'h7777;
        opcode_in       = 8'h50;
        #1;
        total++; if (stall_out !== 1'b1) begin bad++; $display("FAIL st_issue_stall got=%b want=1", stall_out); end
        step();
        dmem_ready = 1'b1;
        dmem_rdata = 16'hDEAD;
        #1;
        total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin bad++;
            $display("FAIL st_req got=%b/%b want=1/1", dmem_req, dmem_we); end
        total++; if (dmem_addr !== 16'h0010 || dmem_wdata !== 16'hA5A5) begin bad++;
            $display("FAIL st_addr_data got=%h/%h want=0010/a5a5", dmem_addr, dmem_wdata); end
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL st_ready_stall got=%b want=0", stall_out); end
        step();
        dmem_ready = 1'b0;
        clear_inputs();
        #1;
        total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL st_req_drop got=%b want=0", dmem_req); end
        total++; if (set_regwrite_out !== 1'b0) begin bad++; $display("FAIL st_regwrite got=%b want=0", set_regwrite_out); end
        total++; if (wb_data_out !== 16'h7777) begin bad++; $display("FAIL st_wb_data got=%h want=7777", wb_data_out); end
    endtask

    task automatic test_timeout();
        set_regwrite_in = 1'b1;
        destreg_in      = 4'h5;
        set_memread_in  = 1'b1;
        addr_in         = 16'h0300;
        opcode_in       = 8'h41;
        dmem_ready      = 1'b0;
        #1;
        total++; if (stall_out !== 1'b1) begin bad++; $display("FAIL to_issue_stall got=%b want=1", stall_out); end
        for (int i = 0; i < 16; i++) begin
            step();
            #1;
            total++; if (dmem_req !== 1'b1 || set_regwrite_out !== 1'b0 || err_timeout_out !== 1'b0) begin bad++;
                $display("FAIL to_wait cyc=%0d got=req%b/rw%b/err%b want=1/0/0", i, dmem_req, set_regwrite_out, err_timeout_out); end
            total++; if (stall_out !== (i != 15)) begin bad++;
                $display("FAIL to_stall cyc=%0d got=%b want=%b", i, stall_out, (i != 15)); end
        end
        step();
        clear_inputs();
        #1;
        total++; if (dmem_req !== 1'b0) begin bad++; $display("FAIL to_req_drop got=%b want=0", dmem_req); end
        total++; if (err_timeout_out !== 1'b1) begin bad++; $display("FAIL to_err got=%b want=1", err_timeout_out); end
        total++; if (wb_data_out !== 16'hFFFF) begin bad++; $display("FAIL to_wb_data got=%h want=ffff", wb_data_out); end
        total++; if (set_regwrite_out !== 1'b0) begin bad++; $display("FAIL to_regwrite got=%b want=0", set_regwrite_out); end
        dmem_ready = 1'b1;   // ready seen in IDLE must be ignored
        step();
        dmem_ready = 1'b0;
        step();
        #1;
        total++; if (err_timeout_out !== 1'b1 || dmem_req !== 1'b0 || stall_out !== 1'b0) begin bad++;
            $display("FAIL to_sticky got=err%b/req%b/stall%b want=1/0/0", err_timeout_out, dmem_req, stall_out); end
    endtask

    task automatic test_reset_mid_access();
        set_regwrite_in = 1'b1;
        destreg_in      = 4'h6;
        set_memread_in  = 1'b1;
        addr_in         = 16'h0444;
        opcode_in       = 8'h42;
        step();              // first ACCESS cycle
        step();              // second ACCESS cycle
        reset = 1'b0;
        #1;
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL rst_mid_stall got=%b want=0", stall_out); end
        step();
        clear_inputs();
        reset = 1'b1;
        #1;
        total++; if (dmem_req !== 1'b0 || err_timeout_out !== 1'b0) begin bad++;
            $display("FAIL rst_mid_req got=req%b/err%b want=0/0", dmem_req, err_timeout_out); end
        total++; if ({set_regwrite_out, destreg_out, wb_data_out, opcode_out} !== 29'd0) begin bad++;
            $display("FAIL rst_mid_wb got=%b/%h/%h/%h want=all zero", set_regwrite_out, destreg_out, wb_data_out, opcode_out); end
        total++; if (stall_out !== 1'b0) begin bad++; $display("FAIL rst_mid_idle got=%b want=0", stall_out); end
        set_regwrite_in = 1'b1;
        destreg_in      = 4'h9;
        result_in       = 16'h0042;
        step();
        clear_inputs();
        #1;
        total++; if (set_regwrite_out !== 1'b1 || destreg_out !== 4'h9 || wb_data_out !== 16'h0042) begin bad++;
            $display("FAIL rst_mid_alu got=%b/%h/%h want=1/9/0042", set_regwrite_out, destreg_out, wb_data_out); end
    endtask

    task automatic test_back_to_back();
        do_load(16'h0100, 16'h1111, 1, 4'h1);
        do_load(16'h0102, 16'h2222, 0, 4'h2);
        clear_inputs();
        step();
        #1;
        total++; if (set_regwrite_out !== 1'b0 || dmem_req !== 1'b0) begin bad++;
            $display("FAIL b2b_tail got=rw%b/req%b want=0/0", set_regwrite_out, dmem_req); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before test sequence ended");
        $fatal(1, "watchdog");
    end

endmodule
